gpio_buttons: RTL and testbench

Memory-mapped GPIO input peripheral for the board push-buttons and switches; the reader-side counterpart of the LED output port. Each pin is synchronised and debounced per bit, and rising edges are captured in sticky status bits. A maskable interrupt request is driven from those bits. It sits on the same single-cycle load/store peripheral bus as the other GPIO blocks: the decoder drives en, the core drives we, wdata and addr, and rdata is read combinationally.

---
 rtl/gpio_buttons.sv | 57 +++++
 tb/tb_gpio_buttons.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/gpio_buttons.sv
// gpio_buttons: debounced GPIO input port with sticky rising-edge capture and maskable irq
module gpio_buttons #(
  parameter int N_IN = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [N_IN-1:0] pins,
  output logic            irq
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [N_IN-1:0] s1, s2, stable, edges, irq_en, done, clr;
  logic [CNT_W-1:0] cnt [N_IN];
  logic wr, unused_wdata;
  assign wr = en & we;
  assign unused_wdata = ^wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pins;
      s2 <= s1;
    end
  always_comb
    for (int j = 0; j < N_IN; j++)
      done[j] = (s2[j] != stable[j]) && (cnt[j] == CNT_W'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stable <= '0;
      for (int j = 0; j < N_IN; j++) cnt[j] <= '0;
    end else begin
      for (int j = 0; j < N_IN; j++)
        cnt[j] <= (s2[j] == stable[j] || done[j]) ? '0 : cnt[j] + CNT_W'(1);
      stable <= stable ^ done;
    end
  // a rise on the same edge as a W1C wins, since set is ORed after the clear
  assign clr = (wr && addr == 2'd1) ? wdata[N_IN-1:0] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      edges  <= '0;
      irq_en <= '0;
    end else begin
      edges <= (edges & ~clr) | (done & s2);
      if (wr && addr == 2'd2) irq_en <= wdata[N_IN-1:0];
    end
  always_comb
    rdata = addr == 2'd0 ? 32'(stable) :
            addr == 2'd1 ? 32'(edges)  :
            addr == 2'd2 ? 32'(irq_en) : '0;
  assign irq = |(edges & irq_en);
endmodule

// File: tb/tb_gpio_buttons.sv
// tb_gpio_buttons: table-driven and directed checks of gpio_buttons with 4-cycle debounce
module tb_gpio_buttons;
  logic clk = 0, rst = 1, en = 0, we = 0, irq;
  logic [1:0] addr = 0;
  logic [31:0] wdata = 0, rdata;
  logic [7:0] pins = 0;
  int checks = 0, errors = 0;

  gpio_buttons #(.N_IN(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .pins(pins), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pins;
    logic        en;
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    int          cyc;
    logic [1:0]  raddr;
    logic [31:0] exp;
    logic        exp_irq;
  } vec_t;
  vec_t v [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    en = 1; we = 1; addr = a; wdata = d;
    step();
    en = 0; we = 0;
  endtask

  initial begin
    v[0]  = '{8'h00, 0, 0, 2'd0, 32'h0,        1, 2'd0, 32'h00, 0};
    v[1]  = '{8'h01, 0, 0, 2'd0, 32'h0,        5, 2'd0, 32'h00, 0};
    v[2]  = '{8'h01, 0, 0, 2'd0, 32'h0,        1, 2'd0, 32'h01, 0};
    v[3]  = '{8'h01, 0, 0, 2'd0, 32'h0,        1, 2'd1, 32'h01, 0};
    v[4]  = '{8'h01, 1, 1, 2'd2, 32'h01,       1, 2'd2, 32'h01, 1};
    v[5]  = '{8'h01, 1, 1, 2'd1, 32'h01,       1, 2'd1, 32'h00, 0};
    v[6]  = '{8'h00, 0, 0, 2'd0, 32'h0,        6, 2'd0, 32'h00, 0};
    v[7]  = '{8'h00, 0, 0, 2'd0, 32'h0,        1, 2'd1, 32'h00, 0};
    v[8]  = '{8'h00, 0, 1, 2'd2, 32'hFF,       1, 2'd2, 32'h01, 0};
    v[9]  = '{8'h00, 1, 1, 2'd0, 32'hFF,       1, 2'd0, 32'h00, 0};
    v[10] = '{8'h00, 1, 1, 2'd3, 32'hFF,       1, 2'd3, 32'h00, 0};
    v[11] = '{8'h00, 1, 1, 2'd2, 32'hFFFFFF00, 1, 2'd2, 32'h00, 0};
    v[12] = '{8'h00, 0, 0, 2'd0, 32'h0,        1, 2'd3, 32'h00, 0};

    repeat (2) step();
    rd("rst_data", 0, 0);
    rd("rst_edge", 1, 0);
    rd("rst_irqen", 2, 0);
    rd("rst_res", 3, 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 0;

    pins = 8'hFF;
    repeat (3) step();
    rst = 1;
    step();
    rst = 0;
    pins = 8'h00;
    for (int c = 0; c < 10; c++) begin
      rd("midrst_data", 0, 0);
      rd("midrst_edge", 1, 0);
      chk("midrst_irq", 32'(irq), 0);
      step();
    end

    for (int n = 0; n < 13; n++) begin
      pins = v[n].pins; en = v[n].en; we = v[n].we;
      addr = v[n].waddr; wdata = v[n].wdata;
      repeat (v[n].cyc) step();
      en = 0; we = 0;
      rd($sformatf("vec%0d_rdata", n), v[n].raddr, v[n].exp);
      chk($sformatf("vec%0d_irq", n), 32'(irq), 32'(v[n].exp_irq));
    end

    for (int r = 0; r < 5; r++) begin
      pins = 8'h08;
      repeat (3) step();
      pins = 8'h00;
      repeat (3) step();
      rd("glitch_data", 0, 0);
      rd("glitch_edge", 1, 0);
    end
    pins = 8'h08;
    repeat (6) step();
    rd("pulse_data", 0, 32'h08);
    rd("pulse_edge", 1, 32'h08);
    wr(1, 32'h08);
    pins = 8'h00;
    repeat (6) step();
    rd("pulse_rel_data", 0, 0);
    rd("pulse_rel_edge", 1, 0);

    wr(2, 32'h02);
    pins = 8'h02;
    repeat (6) step();
    chk("int_irq_set", 32'(irq), 1);
    wr(1, 32'h01);
    chk("int_irq_other_w1c", 32'(irq), 1);
    rd("int_edge_kept", 1, 32'h02);
    wr(1, 32'h02);
    rd("int_edge_clr", 1, 0);
    chk("int_irq_clr", 32'(irq), 0);
    pins = 8'h00;
    repeat (6) step();
    rd("int_fall_edge", 1, 0);
    rd("int_fall_data", 0, 0);

    pins = 8'h20;
    repeat (5) step();
    rd("coll_pre_data", 0, 0);
    wr(1, 32'h20);
    rd("coll_data", 0, 32'h20);
    rd("coll_edge", 1, 32'h20);
    chk("coll_irq_masked", 32'(irq), 0);
    wr(2, 32'h20);
    chk("mask_irq_on", 32'(irq), 1);
    wr(2, 32'h00);
    chk("mask_irq_off", 32'(irq), 0);
    rd("mask_edge", 1, 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
